// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin issue of FP8xFP8+FP16 multiply-accumulate ops from
// NREQ requesters into one shared LAT-deep datapath. Each requester owns an
// FP16 accumulator here. At most one op per requester is in flight. The sum
// being written back can be bypassed straight into a re-issue of the same
// requester, so a single requester can still issue every LAT cycles.
module mac_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [8*NREQ-1:0]         req_a,
    input  logic [8*NREQ-1:0]         req_b,
    input  logic [NREQ-1:0]           req_ae,
    input  logic [NREQ-1:0]           req_be,
    input  logic [NREQ-1:0]           req_first,
    input  logic [NREQ-1:0]           req_last,
    output logic [7:0]                dp_a,
    output logic [7:0]                dp_b,
    output logic                      dp_ae,
    output logic                      dp_be,
    output logic [15:0]               dp_c,
    output logic [LAT-1:0]            dp_save,
    input  logic [15:0]               dp_sum,
    output logic                      res_valid,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic [15:0]               res_data,
    output logic [NREQ-1:0]           busy
);
    localparam int IDW = $clog2(NREQ);

    // Registered state
    logic [LAT-1:0]  vld_r;
    logic [IDW-1:0]  tag_id_r [LAT];
    logic [LAT-1:0]  tag_last_r;
    logic [NREQ-1:0] busy_r;
    logic [15:0]     acc_r [NREQ];
    logic [IDW-1:0]  ptr_r;
    logic [7:0]      dp_a_r;
    logic [7:0]      dp_b_r;
    logic            dp_ae_r;
    logic            dp_be_r;
    logic [15:0]     dp_c_r;
    logic            res_valid_r;
    logic [IDW-1:0]  res_id_r;
    logic [15:0]     res_data_r;

    // Combinational signals
    logic            wb_s;
    logic [IDW-1:0]  wb_id_s;
    logic            wb_last_s;
    logic [NREQ-1:0] wb_oh_s;
    logic [NREQ-1:0] elig_s;
    logic            gnt_any_s;
    logic            gnt_fire_s;
    logic [IDW-1:0]  gnt_id_s;
    logic [IDW-1:0]  idx_s;
    logic [NREQ-1:0] gnt_oh_s;
    logic [NREQ-1:0] busy_nx_s;
    logic [IDW-1:0]  ptr_nx_s;
    logic [7:0]      a_sel_s;
    logic [7:0]      b_sel_s;
    logic            ae_sel_s;
    logic            be_sel_s;
    logic            first_sel_s;
    logic            last_sel_s;
    logic [15:0]     acc_sel_s;
    logic [15:0]     c_sel_s;

    // The op in the last pipeline slot is the one writing back this cycle.
    assign wb_s      = vld_r[LAT-1];
    assign wb_id_s   = tag_id_r[LAT-1];
    assign wb_last_s = tag_last_r[LAT-1];

    // A requester retiring this cycle may be re-granted in the same cycle.
    assign elig_s = req_valid & (~busy_r | wb_oh_s);

    // Round-robin pick starting at ptr_r; the first eligible requester wins.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_id_s  = {IDW{1'b0}};
        idx_s     = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            idx_s = IDW'((int'(ptr_r) + i) % NREQ);
            if (!gnt_any_s && elig_s[idx_s]) begin
                gnt_any_s = 1'b1;
                gnt_id_s  = idx_s;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
        // Abort and reset both suppress any grant.
        gnt_fire_s = gnt_any_s & ~clr & rst_n;
    end

    // One-hot grant/writeback masks and the next busy vector (set beats clear).
    always_comb begin
        gnt_oh_s = {NREQ{1'b0}};
        wb_oh_s  = {NREQ{1'b0}};
        for (int r = 0; r < NREQ; r++) begin
            gnt_oh_s[r] = gnt_fire_s & (gnt_id_s == IDW'(r));
            wb_oh_s[r]  = wb_s & (wb_id_s == IDW'(r));
        end
        busy_nx_s = (busy_r & ~wb_oh_s) | gnt_oh_s;
    end

    assign req_ready = gnt_oh_s;
    assign ptr_nx_s  = (gnt_id_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);

    // Operand mux for the chosen requester; addend is +0, the bypassed sum or acc.
    always_comb begin
        a_sel_s     = 8'h00;
        b_sel_s     = 8'h00;
        ae_sel_s    = 1'b0;
        be_sel_s    = 1'b0;
        first_sel_s = 1'b0;
        last_sel_s  = 1'b0;
        acc_sel_s   = 16'h0000;
        for (int r = 0; r < NREQ; r++) begin
            a_sel_s     = a_sel_s     | (req_a[8*r +: 8] & {8{gnt_id_s == IDW'(r)}});
            b_sel_s     = b_sel_s     | (req_b[8*r +: 8] & {8{gnt_id_s == IDW'(r)}});
            ae_sel_s    = ae_sel_s    | (req_ae[r]    & (gnt_id_s == IDW'(r)));
            be_sel_s    = be_sel_s    | (req_be[r]    & (gnt_id_s == IDW'(r)));
            first_sel_s = first_sel_s | (req_first[r] & (gnt_id_s == IDW'(r)));
            last_sel_s  = last_sel_s  | (req_last[r]  & (gnt_id_s == IDW'(r)));
            acc_sel_s   = acc_sel_s   | (acc_r[r] & {16{gnt_id_s == IDW'(r)}});
        end
        c_sel_s = first_sel_s ? 16'h0000 :
                  (wb_s && (wb_id_s == gnt_id_s)) ? dp_sum : acc_sel_s;
    end

    // Valid/tag pipeline: follows every issued op to its writeback, never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r      <= {LAT{1'b0}};
            tag_last_r <= {LAT{1'b0}};
            for (int k = 0; k < LAT; k++) begin
                tag_id_r[k] <= {IDW{1'b0}};
            end
        end else if (clr) begin
            vld_r <= {LAT{1'b0}};
        end else begin
            vld_r       <= {vld_r[LAT-2:0], gnt_fire_s};
            tag_last_r  <= {tag_last_r[LAT-2:0], last_sel_s};
            tag_id_r[0] <= gnt_id_s;
            for (int k = 1; k < LAT; k++) begin
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    // Stage-0 operand registers: load on a grant, otherwise hold (also across clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a_r  <= 8'h00;
            dp_b_r  <= 8'h00;
            dp_ae_r <= 1'b0;
            dp_be_r <= 1'b0;
            dp_c_r  <= 16'h0000;
        end else if (gnt_fire_s) begin
            dp_a_r  <= a_sel_s;
            dp_b_r  <= b_sel_s;
            dp_ae_r <= ae_sel_s;
            dp_be_r <= be_sel_s;
            dp_c_r  <= c_sel_s;
        end
    end

    // Round-robin pointer and busy interlock bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= {IDW{1'b0}};
            busy_r <= {NREQ{1'b0}};
        end else if (clr) begin
            ptr_r  <= {IDW{1'b0}};
            busy_r <= {NREQ{1'b0}};
        end else begin
            busy_r <= busy_nx_s;
            if (gnt_fire_s) begin
                ptr_r <= ptr_nx_s;
            end
        end
    end

    // Accumulators capture every writeback sum verbatim; clr zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREQ; r++) begin
                acc_r[r] <= 16'h0000;
            end
        end else if (clr) begin
            for (int r = 0; r < NREQ; r++) begin
                acc_r[r] <= 16'h0000;
            end
        end else if (wb_s) begin
            acc_r[wb_id_s] <= dp_sum;
        end
    end

    // Result registers: one-cycle pulse for a writeback tagged as last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_id_r    <= {IDW{1'b0}};
            res_data_r  <= 16'h0000;
        end else if (clr) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= wb_s & wb_last_s;
            if (wb_s && wb_last_s) begin
                res_id_r   <= wb_id_s;
                res_data_r <= dp_sum;
            end
        end
    end

    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign dp_ae     = dp_ae_r;
    assign dp_be     = dp_be_r;
    assign dp_c      = dp_c_r;
    assign dp_save   = vld_r;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_data  = res_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: drives mac_arbiter against a stand-in 4-stage datapath and
// compares every cycle with a behavioural model built from grant history.
module tb_mac_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [3:0]  req_valid, req_ready, req_ae, req_be, req_first, req_last, busy;
    logic [31:0] req_a, req_b;
    logic [7:0]  dp_a, dp_b;
    logic        dp_ae, dp_be;
    logic [15:0] dp_c, dp_sum, res_data;
    logic [3:0]  dp_save;
    logic        res_valid;
    logic [1:0]  res_id;

    mac_arbiter #(.NREQ(N), .LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ae(req_ae), .req_be(req_be),
        .req_first(req_first), .req_last(req_last),
        .dp_a(dp_a), .dp_b(dp_b), .dp_ae(dp_ae), .dp_be(dp_be), .dp_c(dp_c),
        .dp_save(dp_save), .dp_sum(dp_sum),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: any deterministic function will do, the arbiter never
    // looks inside the FP values.
    function automatic logic [15:0] dpf(input logic [7:0] a, input logic [7:0] b,
                                        input logic ae, input logic be, input logic [15:0] c);
        return c + {a, b} + (ae ? 16'h0100 : 16'h0000) + (be ? 16'h0001 : 16'h0000);
    endfunction

    logic [15:0] s1 = 16'h0000, s2 = 16'h0000, s3 = 16'h0000;
    // Three register stages after the operand registers.
    always @(posedge clk) begin
        s1 <= dpf(dp_a, dp_b, dp_ae, dp_be, dp_c);
        s2 <= s1;
        s3 <= s2;
    end
    assign dp_sum = s3;

    // ---------------- behavioural model ----------------
    int          errors = 0, checks = 0, cyc = 0, ptr_m = 0;
    logic [15:0] acc_m [N];
    bit          rg_v [8];
    int          rg_cyc [8];
    int          rg_r [8];
    bit          rg_last [8];
    logic [15:0] rg_sum [8];
    logic [7:0]  m_a = 8'h00, m_b = 8'h00;
    logic        m_ae = 1'b0, m_be = 1'b0;
    logic [15:0] m_c = 16'h0000;
    int          gl[$], sl[$], cl[$], rl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit live(input int t);
        return (t >= 0) && rg_v[t % 8] && (rg_cyc[t % 8] == t);
    endfunction

    // Predict this cycle's outputs, compare, log, then advance the model.
    task automatic step_model();
        logic [3:0]  elig, e_rdy, e_busy, e_save;
        logic [7:0]  e_a, e_b;
        logic        e_ae, e_be, e_rv;
        logic [15:0] e_c, e_data, cv, sum;
        int          g, e_id, slot;
        g = -1; e_rdy = 4'b0000; e_busy = 4'b0000; e_save = 4'b0000;
        e_rv = 1'b0; e_id = 0; e_data = 16'h0000;
        for (int r = 0; r < N; r++) begin
            elig[r] = req_valid[r];
            for (int d = 1; d <= 3; d++)
                if (live(cyc - d) && rg_r[(cyc - d) % 8] == r) elig[r] = 1'b0;
        end
        if (rst_n && !clr)
            for (int i = 0; i < N; i++)
                if (g < 0 && elig[(ptr_m + i) % N]) g = (ptr_m + i) % N;
        if (g >= 0) e_rdy[g] = 1'b1;
        for (int k = 0; k < 4; k++) e_save[k] = live(cyc - 1 - k);
        for (int d = 1; d <= 4; d++)
            if (live(cyc - d)) e_busy[rg_r[(cyc - d) % 8]] = 1'b1;
        if (live(cyc - 5) && rg_last[(cyc - 5) % 8]) begin
            e_rv = 1'b1; e_id = rg_r[(cyc - 5) % 8]; e_data = rg_sum[(cyc - 5) % 8];
        end
        e_a = m_a; e_b = m_b; e_ae = m_ae; e_be = m_be; e_c = m_c;
        if (!rst_n) begin
            e_save = 4'b0000; e_busy = 4'b0000; e_rv = 1'b0;
            e_a = 8'h00; e_b = 8'h00; e_ae = 1'b0; e_be = 1'b0; e_c = 16'h0000;
        end
        chk("req_ready", {28'h0, req_ready}, {28'h0, e_rdy});
        chk("dp_save", {28'h0, dp_save}, {28'h0, e_save});
        chk("busy", {28'h0, busy}, {28'h0, e_busy});
        chk("dp_ops", {14'h0, dp_a, dp_b, dp_ae, dp_be}, {14'h0, e_a, e_b, e_ae, e_be});
        chk("dp_c", {16'h0, dp_c}, {16'h0, e_c});
        chk("res_valid", {31'h0, res_valid}, {31'h0, e_rv});
        if (e_rv) begin
            chk("res_id", {30'h0, res_id}, e_id);
            chk("res_data", {16'h0, res_data}, {16'h0, e_data});
        end
        gl.push_back(g);
        sl.push_back(int'(e_save));
        cl.push_back(int'(e_c));
        rl.push_back(e_rv ? ((e_id << 16) | int'(e_data)) : -1);
        if (!rst_n || clr) begin
            for (int i = 0; i < 8; i++) rg_v[i] = 1'b0;
            for (int r = 0; r < N; r++) acc_m[r] = 16'h0000;
            ptr_m = 0;
            if (!rst_n) begin
                m_a = 8'h00; m_b = 8'h00; m_ae = 1'b0; m_be = 1'b0; m_c = 16'h0000;
            end
        end else begin
            slot = cyc % 8;
            rg_cyc[slot] = cyc;
            rg_v[slot] = (g >= 0);
            if (g >= 0) begin
                cv  = req_first[g] ? 16'h0000 : acc_m[g];
                sum = dpf(req_a[8*g +: 8], req_b[8*g +: 8], req_ae[g], req_be[g], cv);
                acc_m[g] = sum;
                rg_r[slot] = g; rg_last[slot] = req_last[g]; rg_sum[slot] = sum;
                m_a = req_a[8*g +: 8]; m_b = req_b[8*g +: 8];
                m_ae = req_ae[g]; m_be = req_be[g]; m_c = cv;
                ptr_m = (g + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 4'h0; req_first = 4'h0; req_last = 4'h0;
        req_ae = 4'h0; req_be = 4'h0; req_a = 32'h0; req_b = 32'h0;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic f, input logic l);
        req_valid[r] = v; req_a[8*r +: 8] = a; req_b[8*r +: 8] = b;
        req_ae[r] = 1'b1; req_be[r] = 1'b1; req_first[r] = f; req_last[r] = l;
    endtask

    task automatic do_clr();
        idle(); clr = 1'b1; tick(); clr = 1'b0;
    endtask

    int s0, np, nres;
    int p[3];
    int k4[4];
    int exp4[6] = '{1, 3, -1, -1, 1, 3};

    initial begin
        for (int r = 0; r < N; r++) acc_m[r] = 16'h0000;
        for (int i = 0; i < 8; i++) begin rg_v[i] = 1'b0; rg_cyc[i] = -1; end
        rst_n = 1'b0; clr = 1'b0; idle();
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_save", {28'h0, dp_save}, 32'h0);
        chk("rst_busy", {28'h0, busy}, 32'h0);
        chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_dp_c", {16'h0, dp_c}, 32'h0);

        // Single op: 1.0 x 2.0 on requester 0.
        do_clr();
        s0 = gl.size();
        set_req(0, 1'b1, 8'h38, 8'h40, 1'b1, 1'b1);
        tick(); idle();
        repeat (6) tick();
        chk("t1_grant", gl[s0], 0);
        for (int k = 0; k < 4; k++) chk("t1_save", sl[s0 + 1 + k], 1 << k);
        chk("t1_res", rl[s0 + 5], 32'h0000_3941);

        // Bypass chain: three ops from requester 0 alone.
        do_clr();
        s0 = gl.size(); np = 0;
        for (int n = 0; n < 20; n++) begin
            set_req(0, np < 3, 8'h38, 8'h40, np == 0, np == 2);
            tick();
            if (gl[gl.size() - 1] == 0) begin p[np] = gl.size() - 1; np++; end
        end
        idle();
        chk("t2_ngrants", np, 3);
        if (np == 3) begin
            chk("t2_gap1", p[1] - p[0], 4);
            chk("t2_gap2", p[2] - p[1], 4);
            chk("t2_c0", cl[p[0] + 1], 32'h0000);
            chk("t2_c1", cl[p[1] + 1], 32'h3941);
            chk("t2_c2", cl[p[2] + 1], 32'h7282);
            chk("t2_res", rl[p[2] + 5], 32'h0000_ABC3);
        end

        // Full round-robin: four requesters, four 1.0 x 1.0 ops each.
        do_clr();
        s0 = gl.size();
        for (int r = 0; r < N; r++) k4[r] = 0;
        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < N; r++)
                set_req(r, k4[r] < 4, 8'h38, 8'h38, k4[r] == 0, k4[r] == 3);
            tick();
            if (gl[gl.size() - 1] >= 0) k4[gl[gl.size() - 1]]++;
        end
        idle();
        for (int i = 0; i < 16; i++) chk("t3_order", gl[s0 + i], i % 4);
        for (int i = 0; i < 4; i++) chk("t3_res", rl[s0 + 17 + i], (i << 16) | 32'hE4E4);

        // Fairness: requesters 1 and 3 only.
        do_clr();
        s0 = gl.size();
        set_req(1, 1'b1, 8'h38, 8'h40, 1'b1, 1'b1);
        set_req(3, 1'b1, 8'h38, 8'h40, 1'b1, 1'b1);
        repeat (6) tick();
        idle();
        for (int i = 0; i < 6; i++) chk("t4_grant", gl[s0 + i], exp4[i]);

        // clr with two ops in flight.
        do_clr();
        s0 = gl.size();
        set_req(0, 1'b1, 8'h38, 8'h40, 1'b1, 1'b1); tick(); idle();
        set_req(1, 1'b1, 8'h38, 8'h40, 1'b1, 1'b1); tick(); idle();
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t5_busy", {28'h0, busy}, 32'h0);
        set_req(0, 1'b1, 8'h38, 8'h40, 1'b0, 1'b1); tick(); idle();
        repeat (7) tick();
        nres = 0;
        for (int i = s0; i < rl.size(); i++) if (rl[i] != -1) nres++;
        chk("t5_nres", nres, 1);
        chk("t5_c", cl[s0 + 4], 32'h0000);
        chk("t5_res", rl[s0 + 8], 32'h0000_3941);

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 800; n++) begin
            for (int r = 0; r < N; r++)
                set_req(r, $urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            req_ae = 4'($urandom); req_be = 4'($urandom);
            clr = ($urandom_range(0, 63) == 0);
            tick();
            if (n == 400) begin
                #2 rst_n = 1'b0;
                #1;
                chk("t6_ready", {28'h0, req_ready}, 32'h0);
                chk("t6_save", {28'h0, dp_save}, 32'h0);
                chk("t6_busy", {28'h0, busy}, 32'h0);
                chk("t6_res_valid", {31'h0, res_valid}, 32'h0);
                chk("t6_dp", {dp_c, dp_a, dp_b}, 32'h0);
                tick();
                rst_n = 1'b1; clr = 1'b0; idle();
                tick();
                chk("t6_nogrant", gl[gl.size() - 1], -1);
            end
        end
        clr = 1'b0; idle();
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
